// File: rtl/log2_stream.sv
// Streaming fixed-point log2 engine: leading-one normalise, fractional bits by iterative squaring,
// noise-floor clip and a one-entry output register. Define LOG2_STREAM_DB_EN for 20*log10 (dB) output.
module log2_stream #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 8,
    parameter int unsigned LOG_WIDTH  = 16,
    parameter int unsigned CH_WIDTH   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CH_WIDTH-1:0]   ch_in,
    input  logic [LOG_WIDTH-1:0]  floor_lvl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LOG_WIDTH-1:0]  log_out,
    output logic [CH_WIDTH-1:0]   ch_out,
    output logic                  zero_out
);
    localparam int unsigned KW      = $clog2(DATA_WIDTH);
    localparam int unsigned RAW_W   = KW + FRAC_WIDTH;
    localparam int unsigned EXT_W   = LOG_WIDTH + 16;
    localparam int unsigned SQ_W    = 2 * DATA_WIDTH;
    localparam int unsigned CW      = $clog2(FRAC_WIDTH + 1);
    localparam int unsigned DB_GAIN = 24660;

    typedef enum logic [2:0] {IDLE, NORM, FRAC, COMBINE, SCALE, DONE} state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [CH_WIDTH-1:0]    ch_q;
    logic [LOG_WIDTH-1:0]   floor_q;
    logic [KW-1:0]          k_q;
    logic [DATA_WIDTH-1:0]  m_q;
    logic [FRAC_WIDTH-1:0]  frac_q;
    logic [CW-1:0]          cnt_q;
    logic [LOG_WIDTH-1:0]   res_q;
    logic                   zero_q;
`ifdef LOG2_STREAM_DB_EN
    logic [RAW_W-1:0]       raw_q;
`endif

    logic [KW-1:0]          norm_k;
    logic [DATA_WIDTH-1:0]  norm_m;
    logic [SQ_W-1:0]        sq;
    logic [DATA_WIDTH-1:0]  m_d;
    logic                   unused_sq_lo;

    assign in_ready = (state_q == IDLE) && !reset;

    // Leading-one position and mantissa normalised to Q1.(DATA_WIDTH-1)
    always_comb begin
        norm_k = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (data_q[i]) norm_k = KW'(i);
        end
        norm_m = data_q << (KW'(DATA_WIDTH - 1) - norm_k);
    end

    // One squaring step: the integer bit of m*m is the next fraction bit, then renormalise
    assign sq           = SQ_W'(m_q) * SQ_W'(m_q);
    assign m_d          = sq[SQ_W-1] ? sq[SQ_W-1:DATA_WIDTH] : sq[SQ_W-2:DATA_WIDTH-1];
    assign unused_sq_lo = ^sq[DATA_WIDTH-2:0];

    function automatic logic [LOG_WIDTH-1:0] clip_sat(input logic [EXT_W-1:0] v,
                                                      input logic [LOG_WIDTH-1:0] flr);
        logic [EXT_W-1:0] f;
        logic [EXT_W-1:0] d;
        f = EXT_W'(flr);
        d = (v <= f) ? '0 : v - f;
        if (d > EXT_W'({LOG_WIDTH{1'b1}})) return '1;
        return LOG_WIDTH'(d);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            log_out   <= '0;
            ch_out    <= '0;
            zero_out  <= 1'b0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= data_in;
                        ch_q    <= ch_in;
                        floor_q <= floor_lvl;
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    if (data_q == '0) begin
                        res_q   <= '0;
                        zero_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q     <= norm_k;
                        m_q     <= norm_m;
                        frac_q  <= '0;
                        cnt_q   <= '0;
                        zero_q  <= 1'b0;
                        state_q <= FRAC;
                    end
                end
                FRAC: begin
                    m_q    <= m_d;
                    frac_q <= (frac_q << 1) | FRAC_WIDTH'(sq[SQ_W-1]);
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(FRAC_WIDTH - 1)) state_q <= COMBINE;
                end
`ifdef LOG2_STREAM_DB_EN
                COMBINE: begin
                    raw_q   <= {k_q, frac_q};
                    state_q <= SCALE;
                end
                // Amplitude to dB: raw * 20*log10(2) in Q4.12
                SCALE: begin
                    res_q   <= clip_sat((EXT_W'(raw_q) * EXT_W'(DB_GAIN)) >> 12, floor_q);
                    state_q <= DONE;
                end
`else
                COMBINE: begin
                    res_q   <= clip_sat(EXT_W'({k_q, frac_q}), floor_q);
                    state_q <= DONE;
                end
`endif
                // Load the holding register when empty or draining this same cycle
                DONE: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        log_out   <= res_q;
                        ch_out    <= ch_q;
                        zero_out  <= zero_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_log2_stream.sv
// Scoreboard bench for log2_stream: driver pushes expected results, a monitor pops and compares.
module tb_log2_stream;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic [1:0]  ch_in;
    logic [15:0] floor_lvl;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] log_out;
    logic [1:0]  ch_out;
    logic        zero_out;

`ifdef LOG2_STREAM_DB_EN
    localparam int LAT_NZ = 12;
`else
    localparam int LAT_NZ = 11;
`endif

    typedef struct {
        logic [15:0] log;
        logic [1:0]  ch;
        logic        z;
        int          tx;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_seen = 0;

    log2_stream dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .ch_in(ch_in), .floor_lvl(floor_lvl),
        .out_valid(out_valid), .out_ready(out_ready), .log_out(log_out),
        .ch_out(ch_out), .zero_out(zero_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: raw log2 value (hand computed), optional dB scaling, floor clip, saturation
    function automatic logic [15:0] model(input int raw, input int flr);
        int v;
`ifdef LOG2_STREAM_DB_EN
        v = (raw * 24660) >>> 12;
`else
        v = raw;
`endif
        if (v <= flr) return 16'h0000;
        v = v - flr;
        if (v > 65535) v = 65535;
        return 16'(v);
    endfunction

    task automatic send(input logic [15:0] d, input logic [1:0] c, input logic [15:0] f,
                        input int raw, input bit z, input int lat);
        exp_t e;
        int   n;
        in_valid  = 1'b1;
        data_in   = d;
        ch_in     = c;
        floor_lvl = f;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data=%0h in_ready never rose", d);
            in_valid = 1'b0;
            return;
        end
        e.log = model(raw, int'(f));
        e.ch  = c;
        e.z   = z;
        e.tx  = cyc + 1;
        e.lat = lat;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: samples mid-low-phase, clear of the driver's negedge updates
    always @(negedge clk) begin
        #2;
        if (!reset && out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                if (!lat_seen) begin
                    lat_seen = 1'b1;
                    if (sbq[0].lat >= 0) chk("latency", 32'(cyc - sbq[0].tx), 32'(sbq[0].lat));
                end
                if (out_ready) begin
                    chk("log_out", 32'(log_out), 32'(sbq[0].log));
                    chk("ch_out", 32'(ch_out), 32'(sbq[0].ch));
                    chk("zero_out", 32'(zero_out), 32'(sbq[0].z));
                    void'(sbq.pop_front());
                    lat_seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        ch_in     = '0;
        floor_lvl = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_log_out", 32'(log_out), 32'd0);
        chk("reset_ch_out", 32'(ch_out), 32'd0);
        chk("reset_zero_out", 32'(zero_out), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Basic log2 values, floor 0
        send(16'h0001, 2'd0, 16'h0000, 32'h0000, 1'b0, LAT_NZ);
        send(16'h0100, 2'd1, 16'h0000, 32'h0800, 1'b0, LAT_NZ);
        send(16'hFFFF, 2'd2, 16'h0000, 32'h0FFF, 1'b0, LAT_NZ);
        send(16'h0003, 2'd3, 16'h0000, 32'h0195, 1'b0, LAT_NZ);
        // Zero input short path
        send(16'h0000, 2'd2, 16'h0000, 32'h0000, 1'b1, 2);
        // Floor clip and subtraction
        send(16'h0003, 2'd1, 16'h0200, 32'h0195, 1'b0, LAT_NZ);
        send(16'h0100, 2'd0, 16'h0100, 32'h0800, 1'b0, LAT_NZ);
        repeat (15) @(negedge clk);

        // Backpressure: first result held, engine stalls in DONE
        out_ready = 1'b0;
        send(16'h0100, 2'd1, 16'h0000, 32'h0800, 1'b0, LAT_NZ);
        send(16'h0003, 2'd3, 16'h0000, 32'h0195, 1'b0, -1);
        repeat (20) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_log_hold", 32'(log_out), 32'(model(32'h0800, 0)));
        chk("stall_ch_hold", 32'(ch_out), 32'd1);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall_drained", 32'(sbq.size()), 32'd0);

        // Reset during FRAC discards the sample
        send(16'h1234, 2'd2, 16'h0000, 32'h0000, 1'b0, LAT_NZ);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        void'(sbq.pop_back());
        repeat (2) @(negedge clk);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        chk("midreset_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("postreset_in_ready", 32'(in_ready), 32'd1);
        repeat (15) @(negedge clk);
        chk("postreset_no_result", 32'(out_valid), 32'd0);
        send(16'h0100, 2'd3, 16'h0000, 32'h0800, 1'b0, LAT_NZ);

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
